// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 window feeder: default pixel width, FSM
// state encodings and window element indexing.
package conv_pkg;

    localparam int PIX_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KLOAD  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int WIN_N    = 9;
    localparam int WIN_COLS = 3;
    localparam int WIN_TL   = 0;
    localparam int WIN_CUR  = 8;

    // Element index of window position (row, col), row 0 = oldest line.
    function automatic int win_idx(input int row, input int col);
        return row * WIN_COLS + col;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of delay: DEPTH-deep, WIDTH-wide shift register that
// advances only when en is high.
module conv_line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next-state of the shift line.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 3x3 sliding windows plus serially loaded kernel.
// Define CONV_FEEDER_WINCOUNT_EN to add the win_count output.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PIX_W-1:0]   ker_in,
    input  logic               ker_valid,
    output logic               ker_ready,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win_out,
    output logic [9*PIX_W-1:0] ker_out,
    output logic               conv_enable,
    output logic               frame_done,
`ifdef CONV_FEEDER_WINCOUNT_EN
    output logic [15:0]        win_count,
`endif
    output logic               busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [3:0]           kidx_q, kidx_d;
    logic [9*PIX_W-1:0]   ker_q, ker_d;
    logic [9*PIX_W-1:0]   sa_q, sa_d;
    logic [9*PIX_W-1:0]   win_q, win_d;
    logic                 conv_enable_q, conv_enable_d;
    logic                 frame_done_q, frame_done_d;
    logic                 ker_ready_q, pix_ready_q, busy_q;

    logic                 pix_acc_s;
    logic [PIX_W-1:0]     l1_out_s, l2_out_s;
    logic [PIX_W-1:0]     new_col_s [3];

    assign pix_acc_s    = pix_valid && (state_q == ST_STREAM);
    assign new_col_s[0] = l2_out_s;
    assign new_col_s[1] = l1_out_s;
    assign new_col_s[2] = pix_in;

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_acc_s),
        .din   (pix_in),
        .dout  (l1_out_s)
    );

    // The pixel displaced from line 1 becomes the line-2 input.
    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_acc_s),
        .din   (l1_out_s),
        .dout  (l2_out_s)
    );

    // FSM, counters, kernel capture and window shift array.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        kidx_d        = kidx_q;
        ker_d         = ker_q;
        sa_d          = sa_q;
        win_d         = win_q;
        conv_enable_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_KLOAD;
                    col_d   = '0;
                    row_d   = '0;
                    kidx_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KLOAD: begin
                if (ker_valid) begin
                    ker_d[PIX_W*kidx_q +: PIX_W] = ker_in;
                    if (kidx_q == 4'd8) begin
                        state_d = ST_STREAM;
                        kidx_d  = 4'd0;
                    end else begin
                        kidx_d  = kidx_q + 4'd1;
                    end
                end else begin
                    kidx_d = kidx_q;
                end
            end
            ST_STREAM: begin
                if (pix_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        sa_d[PIX_W*win_idx(i, 0) +: PIX_W] = sa_q[PIX_W*win_idx(i, 1) +: PIX_W];
                        sa_d[PIX_W*win_idx(i, 1) +: PIX_W] = sa_q[PIX_W*win_idx(i, 2) +: PIX_W];
                        sa_d[PIX_W*win_idx(i, 2) +: PIX_W] = new_col_s[i];
                    end
                    // Columns 0 and 1 would mix pixels from the previous row.
                    if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
                        win_d         = sa_d;
                        conv_enable_d = 1'b1;
                    end else begin
                        win_d = win_q;
                    end
                    if (col_q == CW'(IMG_W-1)) begin
                        col_d = '0;
                        if (row_q == RW'(IMG_H-1)) begin
                            row_d        = '0;
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    sa_d = sa_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; handshake flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            kidx_q        <= 4'd0;
            ker_q         <= '0;
            sa_q          <= '0;
            win_q         <= '0;
            conv_enable_q <= 1'b0;
            frame_done_q  <= 1'b0;
            ker_ready_q   <= 1'b0;
            pix_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            kidx_q        <= kidx_d;
            ker_q         <= ker_d;
            sa_q          <= sa_d;
            win_q         <= win_d;
            conv_enable_q <= conv_enable_d;
            frame_done_q  <= frame_done_d;
            ker_ready_q   <= (state_d == ST_KLOAD);
            pix_ready_q   <= (state_d == ST_STREAM);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

`ifdef CONV_FEEDER_WINCOUNT_EN
    logic [15:0] win_count_q, win_count_d;

    // Window tally; survives IDLE so the total can be read after the frame.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            win_count_d = 16'd0;
        end else if (conv_enable_q) begin
            win_count_d = win_count_q + 16'd1;
        end else begin
            win_count_d = win_count_q;
        end
    end

    // Window tally register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count_q <= 16'd0;
        end else begin
            win_count_q <= win_count_d;
        end
    end

    assign win_count = win_count_q;
`endif

    assign win_out     = win_q;
    assign ker_out     = ker_q;
    assign conv_enable = conv_enable_q;
    assign frame_done  = frame_done_q;
    assign ker_ready   = ker_ready_q;
    assign pix_ready   = pix_ready_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on a 5x5 image: windows are predicted from
// the driven pixel array and the observed acceptance cycles.
module tb_conv_window_feeder;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int NW = (H - 2) * (W - 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ker_in = 8'd0;
    logic        ker_valid = 1'b0;
    logic        ker_ready;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [71:0] win_out;
    logic [71:0] ker_out;
    logic        conv_enable;
    logic        frame_done;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0]  pix_arr [N];
    logic [71:0] ker_exp = 72'd0;

    int          acc_cyc_q [$];
    int          stb_cyc_q [$];
    logic [71:0] stb_win_q [$];
    int          fd_cyc_q  [$];

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ker_in      (ker_in),
        .ker_valid   (ker_valid),
        .ker_ready   (ker_ready),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .win_out     (win_out),
        .ker_out     (ker_out),
        .conv_enable (conv_enable),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation only: an acceptance seen before edge cyc+1 shows its effect after that edge.
    always @(negedge clk) begin
        if (pix_valid && pix_ready) acc_cyc_q.push_back(cyc + 1);
        if (conv_enable) begin
            stb_cyc_q.push_back(cyc);
            stb_win_q.push_back(win_out);
        end
        if (frame_done) fd_cyc_q.push_back(cyc);
    end

    task automatic set_ramp();
        for (int i = 0; i < N; i++) pix_arr[i] = 8'(i);
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) pix_arr[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || ker_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_kload busy=%b ker_ready=%b required 1 1", busy, ker_ready);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, ker_ready, pix_ready, conv_enable, frame_done} !== 5'b0 ||
            win_out !== 72'd0 || ker_out !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_state flags=%b win=%h ker=%h required all 0",
                     {busy, ker_ready, pix_ready, conv_enable, frame_done}, win_out, ker_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_kernel_load(input logic [71:0] k);
        int i = 0;
        int guard = 0;
        logic go;
        ker_exp = k;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        vectors++;
        if (ker_ready !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL kload_entry ker_ready=%b pix_ready=%b busy=%b required 1 0 1",
                     ker_ready, pix_ready, busy);
        end
        while (i < 9 && guard < 200) begin
            ker_valid = ($urandom_range(0, 3) != 0);
            ker_in    = k[8*i +: 8];
            go        = ker_valid && ker_ready;
            @(posedge clk); #1;
            if (go) i++;
            guard++;
        end
        ker_valid = 1'b0;
        vectors++;
        if (i != 9) begin
            miscompares++;
            $display("FAIL kload_timeout accepted=%0d required 9", i);
        end
        vectors++;
        if (pix_ready !== 1'b1 || ker_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kload_to_stream pix_ready=%b ker_ready=%b required 1 0", pix_ready, ker_ready);
        end
        vectors++;
        if (ker_out !== k) begin
            miscompares++;
            $display("FAIL ker_out got=%h required=%h", ker_out, k);
        end
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random valid with noise on start/kernel
    task automatic test_frame(input int mode, input string tag);
        int idx = 0;
        int guard = 0;
        int j = 0;
        logic go;
        logic [71:0] exp_w;
        acc_cyc_q.delete();
        stb_cyc_q.delete();
        stb_win_q.delete();
        fd_cyc_q.delete();
        while (idx < N && guard < 2000) begin
            case (mode)
                0:       pix_valid = 1'b1;
                1:       pix_valid = (guard % 2 == 0);
                default: pix_valid = 1'($urandom_range(0, 1));
            endcase
            pix_in = pix_arr[idx];
            if (mode == 2) begin
                start     = 1'($urandom_range(0, 1));
                ker_valid = 1'($urandom_range(0, 1));
                ker_in    = 8'($urandom_range(0, 255));
            end
            go = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (go) idx++;
            guard++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        ker_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (idx != N || acc_cyc_q.size() != N) begin
            miscompares++;
            $display("FAIL %s accepted got=%0d/%0d required %0d", tag, idx, acc_cyc_q.size(), N);
        end
        vectors++;
        if (stb_win_q.size() != NW) begin
            miscompares++;
            $display("FAIL %s strobe_count got=%0d required %0d", tag, stb_win_q.size(), NW);
        end
        for (int p = 0; p < N; p++) begin
            int r = p / W;
            int c = p % W;
            if (r >= 2 && c >= 2) begin
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        exp_w[8*(a*3+b) +: 8] = pix_arr[(r-2+a)*W + (c-2+b)];
                if (j < stb_win_q.size() && p < acc_cyc_q.size()) begin
                    vectors++;
                    if (stb_win_q[j] !== exp_w || stb_cyc_q[j] != acc_cyc_q[p]) begin
                        miscompares++;
                        $display("FAIL %s window(%0d,%0d) got=%h@%0d required=%h@%0d",
                                 tag, r, c, stb_win_q[j], stb_cyc_q[j], exp_w, acc_cyc_q[p]);
                    end
                end
                j++;
            end
        end
        vectors++;
        if (fd_cyc_q.size() != 1 || acc_cyc_q.size() != N || stb_cyc_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s frame_done pulses=%0d required 1", tag, fd_cyc_q.size());
        end else if (fd_cyc_q[0] != acc_cyc_q[N-1] || fd_cyc_q[0] != stb_cyc_q[stb_cyc_q.size()-1]) begin
            miscompares++;
            $display("FAIL %s frame_done_cycle got=%0d required %0d", tag, fd_cyc_q[0], acc_cyc_q[N-1]);
        end
        vectors++;
        if (busy !== 1'b0 || pix_ready !== 1'b0 || ker_out !== ker_exp) begin
            miscompares++;
            $display("FAIL %s post_frame busy=%b pix_ready=%b ker=%h required 0 0 %h",
                     tag, busy, pix_ready, ker_out, ker_exp);
        end
    endtask

    task automatic test_ramp_frame(input int mode, input string tag);
        logic [71:0] first_w;
        logic [71:0] last_w;
        first_w = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        last_w  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
        set_ramp();
        test_frame(mode, tag);
        vectors++;
        if (stb_win_q.size() != NW || stb_win_q[0] !== first_w || stb_win_q[NW-1] !== last_w) begin
            miscompares++;
            $display("FAIL %s first_last_window count=%0d first=%h last=%h required %h %h", tag,
                     stb_win_q.size(), (stb_win_q.size() > 0) ? stb_win_q[0] : 72'd0,
                     (stb_win_q.size() > 0) ? stb_win_q[stb_win_q.size()-1] : 72'd0, first_w, last_w);
        end
    endtask

    task automatic test_signed_extremes();
        test_kernel_load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'hFF});
        set_ramp();
        pix_arr[2*W + 2] = 8'h80;
        test_frame(0, "signed");
        vectors++;
        if (stb_win_q.size() == 0 || stb_win_q[0][71:64] !== 8'h80 || ker_out[7:0] !== 8'hFF) begin
            miscompares++;
            $display("FAIL signed_pass win8=%h ker0=%h required 80 ff",
                     (stb_win_q.size() > 0) ? stb_win_q[0][71:64] : 8'h00, ker_out[7:0]);
        end
    endtask

    task automatic test_reset_midop();
        test_kernel_load({8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
        set_random();
        pix_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pix_in = pix_arr[i];
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, ker_ready, pix_ready, conv_enable, frame_done} !== 5'b0 ||
            win_out !== 72'd0 || ker_out !== 72'd0) begin
            miscompares++;
            $display("FAIL midop_reset flags=%b win=%h ker=%h required all 0",
                     {busy, ker_ready, pix_ready, conv_enable, frame_done}, win_out, ker_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_kernel_load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        test_ramp_frame(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_kernel_load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        test_ramp_frame(0, "continuous");
        test_kernel_load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        test_ramp_frame(1, "toggled");
        test_signed_extremes();
        test_kernel_load({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
        set_random();
        test_frame(2, "random_gaps");
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
